uart_tx_sched: RTL and testbench

Transmit scheduler in front of the uart peripheral's register-write port (we/reg_num/wd). After reset it programs the baud divisor and enable. It then merges byte streams from two requesters (CPU store path, debug monitor) into a shared FIFO. It drains the FIFO into the UART data register one byte at a time, paced by the UART busy flag.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_sched_if.sv | 36 +++
 rtl/uart_tx_sched_sync_fifo.sv | 51 +++++
 rtl/uart_tx_sched.sv | 151 +++++++++++++++
 tb/tb_uart_tx_sched.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: UART register map,
// control-register bit positions and the scheduler FSM state encoding.
package uart_pkg;

   localparam logic [2:0] REG_TX   = 3'd0;
   localparam logic [2:0] REG_CTRL = 3'd2;
   localparam logic [2:0] REG_BAUD = 3'd3;

   localparam int CTRL_EN = 0;

   typedef enum logic [2:0] {
      ST_CFG_BAUD,
      ST_CFG_EN,
      ST_IDLE,
      ST_SEND,
      ST_GAP,
      ST_WAIT,
      ST_RECFG
   } state_t;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Bus bundle for uart_tx_sched: two byte requesters, the divisor reprogram
// request, the UART register-write port and status outputs.
// slave = scheduler side, master = requesters / UART / system side.
interface uart_tx_sched_if #(
   parameter int AW = 3
);
   logic          req0_valid;
   logic [7:0]    req0_data;
   logic          req0_ready;
   logic          req1_valid;
   logic [7:0]    req1_data;
   logic          req1_ready;
   logic          cfg_we;
   logic [31:0]   cfg_div;
   logic          u_we;
   logic [2:0]    u_reg_num;
   logic [31:0]   u_wd;
   logic          u_tx_busy;
   logic          init_done;
   logic [AW:0]   fifo_count;

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data,
      input  cfg_we, cfg_div, u_tx_busy,
      output req0_ready, req1_ready, u_we, u_reg_num, u_wd,
      output init_done, fifo_count
   );

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data,
      output cfg_we, cfg_div, u_tx_busy,
      input  req0_ready, req1_ready, u_we, u_reg_num, u_wd,
      input  init_done, fifo_count
   );

endinterface

// File: rtl/uart_tx_sched_sync_fifo.sv
// Single-clock circular FIFO. Pointers wrap naturally at DEPTH (DEPTH must
// be 2**AW). Push when full and pop when empty are ignored.
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int W     = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // storage: contents need no reset, occupancy is tracked by the pointers
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // pointers and occupancy; push+pop together leaves count unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: programs baud divisor and enable after reset,
// merges two byte requesters into a FIFO and drains it into the UART TX
// register one frame at a time, paced by u_tx_busy. Divisor reprogram
// requests are applied only between frames.
// Build option: UART_TX_SCHED_RR_EN selects round-robin arbitration;
// without it requester 0 has fixed priority.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int          DEPTH    = 8,
   parameter logic [31:0] BAUD_DIV = 32'h0000007F,
   parameter int          AW       = 3
) (
   input logic            clk,
   input logic            rst_n,
   uart_tx_sched_if.slave bus
);

   state_t        state, state_d;
   logic          we_q, we_d;
   logic [2:0]    reg_q, reg_d;
   logic [31:0]   wd_q, wd_d;
   logic          init_q, init_d;
   logic          pend_q, clr_pend;
   logic [31:0]   div_q;

   logic          g1, push, pop, full, empty;
   logic [7:0]    push_data, head;
   logic [AW:0]   count;

`ifdef UART_TX_SCHED_RR_EN
   logic rr_q;   // 1: requester 1 preferred on the next contended cycle

   assign g1 = bus.req1_valid & (~bus.req0_valid | rr_q);

   // prefer the side that did not win the last accepted push
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    rr_q <= 1'b0;
      else if (push) rr_q <= ~g1;
   end
`else
   assign g1 = bus.req1_valid & ~bus.req0_valid;
`endif

   assign bus.req0_ready = init_q & ~full & ~g1;
   assign bus.req1_ready = init_q & ~full & g1;
   assign push      = g1 ? bus.req1_valid : (bus.req0_valid & init_q & ~full);
   assign push_data = g1 ? bus.req1_data : bus.req0_data;
   assign pop       = (state == ST_SEND) & ~empty;

   sync_fifo #(.DEPTH(DEPTH), .AW(AW), .W(8)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push & init_q & ~full),
      .din   (push_data),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // latch the requested divisor; a newer request overwrites a pending one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= 1'b0;
         div_q  <= '0;
      end else if (bus.cfg_we) begin
         pend_q <= 1'b1;
         div_q  <= bus.cfg_div;
      end else if (clr_pend) begin
         pend_q <= 1'b0;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_CFG_BAUD;
      else        state <= state_d;
   end

   // next state and next register-write values; reg/wd hold when idle
   always_comb begin
      state_d  = state;
      we_d     = 1'b0;
      reg_d    = reg_q;
      wd_d     = wd_q;
      init_d   = init_q;
      clr_pend = 1'b0;
      case (state)
         ST_CFG_BAUD: begin
            we_d    = 1'b1;
            reg_d   = REG_BAUD;
            wd_d    = BAUD_DIV;
            state_d = ST_CFG_EN;
         end
         ST_CFG_EN: begin
            we_d    = 1'b1;
            reg_d   = REG_CTRL;
            wd_d    = 32'(1) << CTRL_EN;
            init_d  = 1'b1;
            state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (pend_q)      state_d = ST_RECFG;
            else if (!empty) state_d = ST_SEND;
         end
         ST_SEND: begin
            we_d    = 1'b1;
            reg_d   = REG_TX;
            wd_d    = {24'b0, head};
            state_d = ST_GAP;
         end
         // busy rises one cycle after the data write, so skip a cycle
         ST_GAP:  state_d = ST_WAIT;
         ST_WAIT: begin
            if (!bus.u_tx_busy) state_d = ST_IDLE;
         end
         ST_RECFG: begin
            we_d     = 1'b1;
            reg_d    = REG_BAUD;
            wd_d     = div_q;
            clr_pend = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_CFG_BAUD;
      endcase
   end

   // registered UART write port and init flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q   <= 1'b0;
         reg_q  <= '0;
         wd_q   <= '0;
         init_q <= 1'b0;
      end else begin
         we_q   <= we_d;
         reg_q  <= reg_d;
         wd_q   <= wd_d;
         init_q <= init_d;
      end
   end

   assign bus.u_we       = we_q;
   assign bus.u_reg_num  = reg_q;
   assign bus.u_wd       = wd_q;
   assign bus.init_done  = init_q;
   assign bus.fifo_count = count;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched (DEPTH=8). Expected arbitration
// order follows UART_TX_SCHED_RR_EN. A UART model raises busy for 10 cycles
// after each TX-data write; every register write is logged at the negedge.
module tb_uart_tx_sched;
   import uart_pkg::*;

   typedef struct packed { logic [2:0] r; logic [31:0] d; } wr_t;
   typedef struct { int src; logic [7:0] data; logic [31:0] exp_wd; } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       hold_busy;
   logic       saw_tx;
   int         busy_cnt;
   int         viol = 0;
   int         checks = 0;
   int         errors = 0;
   wr_t        wlog[$];
   wr_t        exp_q[$];
   logic [7:0] q0[$], q1[$];

   uart_tx_sched_if #(.AW(3)) bus();

   assign bus.u_tx_busy = hold_busy | (busy_cnt != 0);

   uart_tx_sched #(.DEPTH(8), .BAUD_DIV(32'h0000007F), .AW(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // log every register write; flag writes issued while the UART is busy
   always @(negedge clk) begin
      saw_tx <= bus.u_we && (bus.u_reg_num == REG_TX);
      if (bus.u_we) begin
         wlog.push_back({bus.u_reg_num, bus.u_wd});
         if (bus.u_tx_busy && !hold_busy) viol <= viol + 1;
      end
   end

   // UART busy model: 10 cycles, starting the cycle after the data write
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)            busy_cnt <= 0;
      else if (saw_tx)       busy_cnt <= 10;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end

   function automatic wr_t mk(input logic [2:0] r, input logic [31:0] d);
      wr_t w;
      w.r = r;
      w.d = d;
      return w;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic chk_log(input string name);
      chk({name, " len"}, 64'(wlog.size()), 64'(exp_q.size()));
      foreach (exp_q[i]) begin
         wr_t g;
         g = '1;
         if (i < wlog.size()) g = wlog[i];
         chk($sformatf("%s[%0d]", name, i), 64'(g), 64'(exp_q[i]));
      end
   endtask

   // present queued bytes each cycle; a byte leaves its queue once accepted
   task automatic stream(input int budget, output int left);
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
         bus.req0_valid = (q0.size() != 0);
         bus.req1_valid = (q1.size() != 0);
         if (q0.size() != 0) bus.req0_data = q0[0];
         if (q1.size() != 0) bus.req1_data = q1[0];
         #1;
         if (bus.req0_valid && bus.req0_ready) void'(q0.pop_front());
         if (bus.req1_valid && bus.req1_ready) void'(q1.pop_front());
         @(negedge clk);
         n++;
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      left = q0.size() + q1.size();
   endtask

   task automatic wait_quiet(input string name);
      int streak = 0;
      int n = 0;
      while (streak < 6 && n < 1000) begin
         @(negedge clk);
         n++;
         if (bus.fifo_count == 0 && !bus.u_tx_busy && !bus.u_we) streak++;
         else streak = 0;
      end
      if (streak < 6) begin
         checks++;
         errors++;
         $display("FAIL %s quiet: got timeout expected idle", name);
      end
   endtask

   task automatic wait_busy(input string name);
      int n = 0;
      while (!bus.u_tx_busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.u_tx_busy) begin
         checks++;
         errors++;
         $display("FAIL %s busy: got timeout expected busy", name);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      wlog.delete();
   endtask

   initial begin
      vec_t vt[5];
      int   left;
      int   n;

      vt[0] = '{0, 8'h55, 32'h0000_0055};
      vt[1] = '{1, 8'h3C, 32'h0000_003C};
      vt[2] = '{0, 8'h00, 32'h0000_0000};
      vt[3] = '{1, 8'hFF, 32'h0000_00FF};
      vt[4] = '{0, 8'hA5, 32'h0000_00A5};

      rst_n          = 1'b0;
      hold_busy      = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req0_data  = 8'h00;
      bus.req1_valid = 1'b0;
      bus.req1_data  = 8'h00;
      bus.cfg_we     = 1'b0;
      bus.cfg_div    = 32'h0;

      // reset state
      @(negedge clk);
      bus.req0_valid = 1'b1;
      #1;
      chk("rst u_we",      64'(bus.u_we),       64'h0);
      chk("rst reg",       64'(bus.u_reg_num),  64'h0);
      chk("rst wd",        64'(bus.u_wd),       64'h0);
      chk("rst init_done", 64'(bus.init_done),  64'h0);
      chk("rst count",     64'(bus.fifo_count), 64'h0);
      chk("rst ready0",    64'(bus.req0_ready), 64'h0);
      bus.req0_valid = 1'b0;

      // init sequence
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("init0 we",   64'(bus.u_we),      64'h1);
      chk("init0 reg",  64'(bus.u_reg_num), 64'h3);
      chk("init0 wd",   64'(bus.u_wd),      64'h7F);
      chk("init0 done", 64'(bus.init_done), 64'h0);
      @(negedge clk);
      chk("init1 we",   64'(bus.u_we),      64'h1);
      chk("init1 reg",  64'(bus.u_reg_num), 64'h2);
      chk("init1 wd",   64'(bus.u_wd),      64'h1);
      chk("init1 done", 64'(bus.init_done), 64'h1);
      @(negedge clk);
      chk("init2 we",   64'(bus.u_we),      64'h0);
      chk("init2 reg",  64'(bus.u_reg_num), 64'h2);
      chk("init2 wd",   64'(bus.u_wd),      64'h1);
      repeat (10) @(negedge clk);
      exp_q.delete();
      exp_q.push_back(mk(3'd3, 32'h7F));
      exp_q.push_back(mk(3'd2, 32'h1));
      chk_log("init log");
      wlog.delete();

      // single-byte vectors
      foreach (vt[i]) begin
         if (vt[i].src == 0) q0.push_back(vt[i].data);
         else                q1.push_back(vt[i].data);
         stream(50, left);
         chk($sformatf("vec%0d accept", i), 64'(left), 64'h0);
         wait_quiet($sformatf("vec%0d", i));
         exp_q.delete();
         exp_q.push_back(mk(REG_TX, vt[i].exp_wd));
         chk_log($sformatf("vec%0d log", i));
         wlog.delete();
      end

      // back-to-back bytes: second write waits for the first frame
      q0.push_back(8'h55);
      q0.push_back(8'h56);
      stream(50, left);
      wait_quiet("b2b");
      exp_q.delete();
      exp_q.push_back(mk(REG_TX, 32'h55));
      exp_q.push_back(mk(REG_TX, 32'h56));
      chk_log("b2b log");

      // contention between the two requesters
      do_reset();
      for (int i = 0; i < 4; i++) begin
         q0.push_back(8'hA0 + 8'(i));
         q1.push_back(8'hB0 + 8'(i));
      end
      stream(100, left);
      chk("cont accept", 64'(left), 64'h0);
      wait_quiet("cont");
      exp_q.delete();
`ifdef UART_TX_SCHED_RR_EN
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(mk(REG_TX, 32'hA0 + 32'(i)));
         exp_q.push_back(mk(REG_TX, 32'hB0 + 32'(i)));
      end
`else
      for (int i = 0; i < 4; i++) exp_q.push_back(mk(REG_TX, 32'hA0 + 32'(i)));
      for (int i = 0; i < 4; i++) exp_q.push_back(mk(REG_TX, 32'hB0 + 32'(i)));
`endif
      chk_log("cont log");
      wlog.delete();

      // full FIFO: one byte goes out, then 8 fill the FIFO, the 10th waits
      hold_busy = 1'b1;
      for (int i = 0; i < 10; i++) q0.push_back(8'h10 + 8'(i));
      stream(20, left);
      chk("full left", 64'(left), 64'h1);
      bus.req0_valid = 1'b1;
      bus.req0_data  = q0[0];
      bus.req1_valid = 1'b1;
      #1;
      chk("full count",  64'(bus.fifo_count), 64'h8);
      chk("full ready0", 64'(bus.req0_ready), 64'h0);
      chk("full ready1", 64'(bus.req1_ready), 64'h0);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      hold_busy = 1'b0;
      @(negedge clk);
      stream(200, left);
      chk("full drain accept", 64'(left), 64'h0);
      wait_quiet("full");
      exp_q.delete();
      for (int i = 0; i < 10; i++) exp_q.push_back(mk(REG_TX, 32'h10 + 32'(i)));
      chk_log("full log");
      wlog.delete();

      // reprogram between frames; last of two pending requests wins
      q0.push_back(8'h66);
      stream(50, left);
      wait_busy("recfg a");
      bus.cfg_we  = 1'b1;
      bus.cfg_div = 32'h1F;
      @(negedge clk);
      bus.cfg_we  = 1'b0;
      q0.push_back(8'h77);
      stream(50, left);
      n = 0;
      while (wlog.size() < 3 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("recfg third write", 64'(wlog.size() >= 3), 64'h1);
      wait_busy("recfg b");
      bus.cfg_we  = 1'b1;
      bus.cfg_div = 32'h2E;
      @(negedge clk);
      bus.cfg_we  = 1'b0;
      @(negedge clk);
      bus.cfg_we  = 1'b1;
      bus.cfg_div = 32'h3D;
      @(negedge clk);
      bus.cfg_we  = 1'b0;
      q0.push_back(8'h88);
      stream(50, left);
      wait_quiet("recfg");
      exp_q.delete();
      exp_q.push_back(mk(REG_TX,   32'h66));
      exp_q.push_back(mk(REG_BAUD, 32'h1F));
      exp_q.push_back(mk(REG_TX,   32'h77));
      exp_q.push_back(mk(REG_BAUD, 32'h3D));
      exp_q.push_back(mk(REG_TX,   32'h88));
      chk_log("recfg log");
      wlog.delete();

      // async reset while waiting on a frame with 3 bytes queued
      hold_busy = 1'b1;
      for (int i = 1; i <= 4; i++) q0.push_back(8'(i));
      stream(20, left);
      repeat (3) @(negedge clk);
      chk("mid count", 64'(bus.fifo_count), 64'h3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid rst we",    64'(bus.u_we),       64'h0);
      chk("mid rst reg",   64'(bus.u_reg_num),  64'h0);
      chk("mid rst wd",    64'(bus.u_wd),       64'h0);
      chk("mid rst count", 64'(bus.fifo_count), 64'h0);
      chk("mid rst init",  64'(bus.init_done),  64'h0);
      hold_busy = 1'b0;
      @(negedge clk);
      wlog.delete();
      @(negedge clk);
      rst_n = 1'b1;
      wait_quiet("replay");
      exp_q.delete();
      exp_q.push_back(mk(REG_BAUD, 32'h7F));
      exp_q.push_back(mk(REG_CTRL, 32'h1));
      chk_log("replay log");

      chk("write while busy", 64'(viol), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
